// File: rtl/hockey_input_cond.sv
// hockey_input_cond: front end for the air-hockey game FSM.
// Each player's raw button, direction and Y switches are synchronised through
// two flops. A debounce FSM turns the button into one pulse per accepted press,
// and DIR/Y are captured together with that pulse. A free-running divider
// produces the game tick.
//
// Handshake: BTN_A/BTN_B/tick are single-cycle strobes with no backpressure.
// DIR_x/Y_in_x are valid from the cycle BTN_x is high and hold until the next
// accepted press.
// o_dbg_state exposes {player B state, player A state} (RELEASED=0,
// PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3).
module hockey_input_cond #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20,
  parameter int TICK_DIV   = 4,
  parameter int TICK_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a_raw,
  input  logic       btn_b_raw,
  input  logic [1:0] dir_a_raw,
  input  logic [1:0] dir_b_raw,
  input  logic [2:0] y_a_raw,
  input  logic [2:0] y_b_raw,
  output logic       BTN_A,
  output logic       BTN_B,
  output logic [1:0] DIR_A,
  output logic [1:0] DIR_B,
  output logic [2:0] Y_in_A,
  output logic [2:0] Y_in_B,
  output logic       tick,
  output logic [3:0] o_dbg_state
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  // Index 0 is player A, index 1 is player B. Vector layout: {btn, dir[1:0], y[2:0]}.
  logic [5:0]        w_raw     [2];
  logic [5:0]        r_s1      [2];
  logic [5:0]        r_s2      [2];
  deb_state_t        r_state   [2];
  deb_state_t        w_state_nxt [2];
  logic [CNT_W-1:0]  r_cnt     [2];
  logic [CNT_W-1:0]  w_cnt_nxt [2];
  logic              w_accept  [2];
  logic              r_btn     [2];
  logic [4:0]        r_data    [2];
  logic [TICK_W-1:0] r_tick_cnt;

  assign w_raw[0] = {btn_a_raw, dir_a_raw, y_a_raw};
  assign w_raw[1] = {btn_b_raw, dir_b_raw, y_b_raw};

  // Two-flop synchronisers on every raw input; only r_s2 is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        r_s1[p] <= '0;
        r_s2[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_s1[p] <= w_raw[p];
        r_s2[p] <= r_s1[p];
      end
    end
  end

  // Debounce next-state logic; w_accept marks the PRESS_WAIT -> PRESSED transition.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_state_nxt[p] = r_state[p];
      w_cnt_nxt[p]   = r_cnt[p];
      w_accept[p]    = 1'b0;
      case (r_state[p])
        RELEASED: begin
          if (r_s2[p][5]) begin
            w_state_nxt[p] = PRESS_WAIT;
            w_cnt_nxt[p]   = CNT_W'(1);
          end else begin
            w_cnt_nxt[p]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_s2[p][5]) begin
            w_state_nxt[p] = RELEASED;
            w_cnt_nxt[p]   = '0;
          end else if (r_cnt[p] == DEB_LAST) begin
            w_state_nxt[p] = PRESSED;
            w_cnt_nxt[p]   = '0;
            w_accept[p]    = 1'b1;
          end else begin
            w_cnt_nxt[p]   = r_cnt[p] + CNT_W'(1);
          end
        end
        PRESSED: begin
          // Holding the button never re-triggers.
          if (!r_s2[p][5]) begin
            w_state_nxt[p] = RELEASE_WAIT;
            w_cnt_nxt[p]   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          // A short low glitch falls back to PRESSED without a new pulse.
          if (r_s2[p][5]) begin
            w_state_nxt[p] = PRESSED;
            w_cnt_nxt[p]   = '0;
          end else if (r_cnt[p] == DEB_LAST) begin
            w_state_nxt[p] = RELEASED;
            w_cnt_nxt[p]   = '0;
          end else begin
            w_cnt_nxt[p]   = r_cnt[p] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[p] = RELEASED;
          w_cnt_nxt[p]   = '0;
        end
      endcase
    end
  end

  // Debounce state/counter registers plus the registered pulse and captured DIR/Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= RELEASED;
        r_cnt[p]   <= '0;
        r_btn[p]   <= 1'b0;
        r_data[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= w_state_nxt[p];
        r_cnt[p]   <= w_cnt_nxt[p];
        r_btn[p]   <= w_accept[p];
        if (w_accept[p]) begin
          r_data[p] <= r_s2[p][4:0];
        end
      end
    end
  end

  // Free-running game tick divider, 0..TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  assign tick        = (r_tick_cnt == TICK_LAST);
  assign BTN_A       = r_btn[0];
  assign BTN_B       = r_btn[1];
  assign DIR_A       = r_data[0][4:3];
  assign Y_in_A      = r_data[0][2:0];
  assign DIR_B       = r_data[1][4:3];
  assign Y_in_B      = r_data[1][2:0];
  assign o_dbg_state = {r_state[1], r_state[0]};

endmodule
